// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO and issue sequencer in front of a combinational ALU
//
// Accepts operand/opcode commands on a valid/ready handshake, buffers them in
// a DEPTH-entry circular FIFO, issues one command at a time to the ALU,
// captures the 2N-bit result and presents it in order on a second handshake.
//
// Optional build macro: ALU_CMD_SEQ_BYPASS_EN
//   defined   - a command accepted while IDLE with an empty FIFO loads the ALU
//               drive registers directly (result one cycle earlier)
//   undefined - every command passes through the FIFO
//
// Ports:
//   clk, rstn                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake
//   cmd_op1, cmd_op2, cmd_opcode       command payload
//   alu_operand1/2, alu_operation      registered drive to the ALU
//   alu_result                         2N-bit result from the ALU
//   res_valid/res_ready                result handshake
//   res_data, res_opcode               captured result and its opcode
//   busy                               FIFO non-empty or sequencer not idle

module alu_cmd_sequencer #(
    parameter int N     = 4,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [N-1:0]   cmd_op1,
    input  logic [N-1:0]   cmd_op2,
    input  logic [3:0]     cmd_opcode,
    output logic [N-1:0]   alu_operand1,
    output logic [N-1:0]   alu_operand2,
    output logic [3:0]     alu_operation,
    input  logic [2*N-1:0] alu_result,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_data,
    output logic [3:0]     res_opcode,
    output logic           busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [N-1:0] fifo_op1 [DEPTH];
    logic [N-1:0] fifo_op2 [DEPTH];
    logic [3:0]   fifo_opc [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr, rd_ptr;
    logic        fifo_empty, fifo_full;
    logic        cmd_fire, bypass, push, pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Registered FIFO state only; a same-cycle pop does not raise cmd_ready.
    assign cmd_ready = !fifo_full;
    assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef ALU_CMD_SEQ_BYPASS_EN
    // Only legal with an empty FIFO, so ordering is preserved.
    assign bypass = (state == IDLE) && fifo_empty && cmd_fire;
`else
    assign bypass = 1'b0;
`endif

    assign push = cmd_fire && !bypass;
    assign busy = !fifo_empty || (state != IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end else if (bypass) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_op1[i] <= '0;
                fifo_op2[i] <= '0;
                fifo_opc[i] <= '0;
            end
        end else if (push) begin
            fifo_op1[wr_ptr[AW-1:0]] <= cmd_op1;
            fifo_op2[wr_ptr[AW-1:0]] <= cmd_op2;
            fifo_opc[wr_ptr[AW-1:0]] <= cmd_opcode;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ALU drive registers change only when a command is issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_operand1  <= '0;
            alu_operand2  <= '0;
            alu_operation <= '0;
        end else if (pop) begin
            alu_operand1  <= fifo_op1[rd_ptr[AW-1:0]];
            alu_operand2  <= fifo_op2[rd_ptr[AW-1:0]];
            alu_operation <= fifo_opc[rd_ptr[AW-1:0]];
        end else if (bypass) begin
            alu_operand1  <= cmd_op1;
            alu_operand2  <= cmd_op2;
            alu_operation <= cmd_opcode;
        end
    end

    // ALU inputs have been stable for the whole ISSUE cycle; capture at its end.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_opcode <= '0;
        end else if (state == ISSUE) begin
            res_valid  <= 1'b1;
            res_data   <= alu_result;
            res_opcode <= alu_operation;
        end else if ((state == HOLD) && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a stand-in ALU

module tb_alu_cmd_sequencer;

    localparam int N = 4;
`ifdef ALU_CMD_SEQ_BYPASS_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 3;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [N-1:0]   cmd_op1, cmd_op2;
    logic [3:0]     cmd_opcode;
    logic [N-1:0]   alu_operand1, alu_operand2;
    logic [3:0]     alu_operation;
    logic [2*N-1:0] alu_result;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_data;
    logic [3:0]     res_opcode;
    logic           busy;

    int n_pass = 0;
    int n_chk  = 0;
    int n_res  = 0;
    int cyc    = 0;
    logic [11:0] sb [$];

    alu_cmd_sequencer #(.N(N), .DEPTH(4)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_opcode(cmd_opcode),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_operation(alu_operation), .alu_result(alu_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_opcode(res_opcode), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU: 0 add, 1 subtract, 2 multiply, others xor-concat.
    always_comb begin
        case (alu_operation)
            4'h0:    alu_result = {4'h0, alu_operand1} + {4'h0, alu_operand2};
            4'h1:    alu_result = {4'h0, alu_operand1} - {4'h0, alu_operand2};
            4'h2:    alu_result = alu_operand1 * alu_operand2;
            default: alu_result = {alu_operand1, alu_operand2} ^ 8'h5A;
        endcase
    end

    function automatic logic [7:0] exp_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] ea, eb;
        ea = {4'h0, a};
        eb = {4'h0, b};
        if (op == 4'h0)      return ea + eb;
        else if (op == 4'h1) return ea - eb;
        else if (op == 4'h2) return ea * eb;
        else                 return {a, b} ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Scoreboard: expected results pushed on command acceptance, popped on result handshake.
    always @(negedge clk) begin
        if (rstn && cmd_valid && cmd_ready)
            sb.push_back({cmd_opcode, exp_alu(cmd_opcode, cmd_op1, cmd_op2)});
        if (rstn && res_valid && res_ready) begin
            n_res++;
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("sb_result", 32'({res_opcode, res_data}), 32'(sb.pop_front()));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic acc;
        cmd_valid  = 1'b1;
        cmd_op1    = a;
        cmd_op2    = b;
        cmd_opcode = op;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic wait_res_valid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        chk("wait_res_valid", 32'(seen), 32'd1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && !busy && !res_valid;
        end
        chk("drain", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int k;
        int t0;
        int hs [$];
        logic will_acc;

        // 1. reset values
        rstn = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op1 = '0; cmd_op2 = '0; cmd_opcode = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_in", 32'({alu_operand1, alu_operand2, alu_operation}), 32'd0);
        chk("rst_res", 32'({res_opcode, res_data}), 32'd0);
        @(posedge clk); #1; rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_res_valid", 32'(res_valid), 32'd0);
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // 2. single add, latency
        res_ready = 1'b1;
        send(4'h3, 4'h5, 4'h0);
        cmd_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            @(negedge clk);
            if (res_valid) k = i;
        end
        chk("latency", 32'(k), 32'(LAT));
        chk("add_data", 32'(res_data), 32'h08);
        chk("add_opcode", 32'(res_opcode), 32'h0);
        @(posedge clk); #1;
        drain();

        // 3. backpressure and capacity
        res_ready = 1'b0;
        t0 = cyc;
        send(4'hF, 4'hF, 4'h2);
        send(4'h1, 4'h2, 4'h0);
        send(4'h7, 4'h3, 4'h1);
        send(4'h4, 4'h4, 4'h2);
        send(4'hA, 4'h6, 4'h5);
        chk("b2b_accepts", 32'(cyc - t0), 32'd5);
        cmd_valid = 1'b1; cmd_op1 = 4'h2; cmd_op2 = 4'h9; cmd_opcode = 4'h3;
        repeat (4) begin
            @(negedge clk);
            chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res_data", 32'(res_data), 32'hE1);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        hs.delete();
        for (int i = 0; i < 40 && hs.size() < 5; i++) begin
            @(negedge clk);
            will_acc = cmd_valid && cmd_ready;
            if (res_valid) hs.push_back(cyc);
            @(posedge clk); #1;
            if (will_acc) cmd_valid = 1'b0;
        end
        chk("five_results", 32'(hs.size()), 32'd5);
        for (int i = 1; i < hs.size(); i++) chk("result_spacing", 32'(hs[i] - hs[i-1]), 32'd2);
        cmd_valid = 1'b0;
        drain();

        // 4a. simultaneous push and pop with one entry queued
        res_ready = 1'b0;
        send(4'h2, 4'h3, 4'h2);
        send(4'h8, 4'h1, 4'h1);
        cmd_valid = 1'b0;
        wait_res_valid();
        @(posedge clk); #1;
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op1 = 4'hC; cmd_op2 = 4'h3; cmd_opcode = 4'h0;
        @(negedge clk);
        chk("pp_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("pp_res_valid_pre", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pp_res_valid_gap", 32'(res_valid), 32'd0);
        chk("pp_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        drain();

        // 4b. pointer wrap over 10 commands
        t0 = n_res;
        for (int i = 0; i < 10; i++)
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
        cmd_valid = 1'b0;
        drain();
        chk("wrap_count", 32'(n_res - t0), 32'd10);

        // 5. reset while holding with three queued
        res_ready = 1'b0;
        send(4'h5, 4'h5, 4'h2);
        send(4'h6, 4'h1, 4'h0);
        send(4'h9, 4'h2, 4'h1);
        send(4'h3, 4'h3, 4'h2);
        cmd_valid = 1'b0;
        wait_res_valid();
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_res", 32'({res_opcode, res_data}), 32'd0);
        chk("mid_rst_alu_in", 32'({alu_operand1, alu_operand2, alu_operation}), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1; res_ready = 1'b1;
        t0 = n_res;
        repeat (10) @(negedge clk);
        chk("no_stale_results", 32'(n_res - t0), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // 6. idle cycles hold ALU inputs
        send(4'h9, 4'h6, 4'h1);
        cmd_valid = 1'b0;
        drain();
        repeat (5) begin
            @(negedge clk);
            chk("idle_alu_in", 32'({alu_operand1, alu_operand2, alu_operation}), 32'h961);
            chk("idle_res_valid", 32'(res_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream command stage for the N-bit ALU. Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. Issues one command at a time to the combinational ALU, captures its 2N-bit result, and presents results in order over a second valid/ready handshake.

Parameters:
N, 4, operand width; must match the ALU's N.
DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
clk  in  1  rising-edge clock.
rstn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept a command.
cmd_op1  in  N  first operand.
cmd_op2  in  N  second operand.
cmd_opcode  in  4  ALU operation code.
alu_operand1  out  N  to ALU operand1.
alu_operand2  out  N  to ALU operand2.
alu_operation  out  4  to ALU operation.
alu_result  in  2N  from ALU alu_out.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_data  out  2N  captured ALU result.
res_opcode  out  4  opcode that produced res_data.
busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Clock and reset: one clock. rstn is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values: FIFO empty, cmd_ready=1, alu_operand1/2=0, alu_operation=0, res_valid=0, res_data=0, res_opcode=0, busy=0, FSM in IDLE.
- Command acceptance: cmd_ready = !fifo_full; it is registered FIFO state only and ignores a same-cycle pop. A command is accepted on an edge where cmd_valid && cmd_ready. Push and pop in the same cycle are both legal.
- FIFO: ordered by circular read/write pointers with wrap-around at DEPTH. Commands are never dropped or reordered.
- FSM state IDLE: if FIFO is non-empty, pop the head into the ALU drive registers (operands, opcode) and go to ISSUE.
- FSM state ISSUE: ALU inputs are stable for this whole cycle. At the end of the cycle, latch alu_result into res_data and the opcode into res_opcode, set res_valid=1, and go to HOLD.
- FSM state HOLD: res_valid=1 and res_data/res_opcode hold stable until res_ready=1. On the handshake edge: if the FIFO is non-empty, pop the next command and go directly to ISSUE (res_valid=0 for one cycle); otherwise clear res_valid and go to IDLE.
- Latency: command accepted at the end of cycle c gives res_valid=1 in cycle c+3. Sustained throughput is one result per 2 cycles.
- ALU drive registers change only on a pop and otherwise hold their last values.
- Capacity before cmd_ready falls, with res_ready held low: DEPTH+1 commands (DEPTH in the FIFO plus one in HOLD).
- Empty FIFO in IDLE: no issue occurs; outputs hold.
- Full FIFO with cmd_valid=1: the command is not accepted, and the producer must hold it.
- Reset mid-operation: in-flight and buffered commands are discarded and all outputs return to their reset values.
- Arithmetic: none in this block. Opcode decode and result width belong to the ALU, and results pass through unmodified.
- busy = !fifo_empty || state != IDLE.

Optional Feature:
ALU_CMD_SEQ_BYPASS_EN
- Defined: in IDLE with the FIFO empty, an accepted command loads the ALU drive registers directly, skipping the FIFO, and the FSM goes to ISSUE. Latency drops to res_valid in cycle c+2. Ordering is preserved because bypass applies only when the FIFO is empty.
- Undefined: every command passes through the FIFO, with latency c+3 as specified above.

Test Plan:
Bench instantiates the ALU with N=4; opcode 4'h0 = add, 4'h2 = multiply.
1. Assert rstn=0 -> every output at its reset value, cmd_ready=1. Release -> state unchanged, busy=0.
2. Single command op1=4'h3, op2=4'h5, opcode 4'h0, res_ready=1 -> res_valid=1 in cycle c+3 with res_data=8'h08 and res_opcode=4'h0. With the bypass macro defined: cycle c+2.
3. res_ready=0 and 6 back-to-back commands (4'hF*4'hF multiply first) -> cmd_ready=0 after 5 accepts. res_data=8'hE1 holds stable. Releasing res_ready gives 5 results in order, one every 2 cycles.
4. Simultaneous push and pop with FIFO holding 1 entry -> count unchanged, no loss. Pointer wrap exercised over 10 commands -> all results in order.
5. Assert rstn while in HOLD with 3 queued commands -> res_valid=0 and busy=0 immediately. After release, no stale results appear.
6. Idle cycles with cmd_valid=0 -> ALU inputs hold their last values, res_valid stays 0.
